// File: rtl/fifo_rd_stream_adapter.sv
// Purpose: drains a synchronous FIFO (registered data_out) into a valid/ready stream framed into BURST_LEN-beat bursts.
// Latency: fifo_r_en in cycle N -> fifo_data captured in N+1 -> m_valid in N+2; 1 word/cycle sustained.
// Backpressure: 2-entry skid buffer; reads are issued only when buffer + in-flight read leave room, so no word is ever lost.
//
// Ports:
//   clk, rst_n       single clock, asynchronous active-low reset (shared with the FIFO)
//   fifo_empty       FIFO empty flag
//   fifo_r_en        FIFO read enable (combinational, forced low in reset)
//   fifo_data        FIFO registered read data, meaningful the cycle after fifo_r_en
//   m_valid/m_ready  output stream handshake
//   m_data           output word (buffer head)
//   m_last           high on the final beat of each burst
//   beats_total      accepted-beat count, only when FIFO_DRAIN_STAT_EN is defined
module fifo_rd_stream_adapter #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    output logic                  fifo_r_en,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last
`ifdef FIFO_DRAIN_STAT_EN
    ,
    output logic [31:0]           beats_total
`endif
);

    localparam int              BW        = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BW-1:0]   LAST_BEAT = BW'(BURST_LEN - 1);

    logic                  inflight;
    logic [1:0]            count;
    logic                  head;
    logic                  tail;
    logic [DATA_WIDTH-1:0] obuf [2];
    logic [BW-1:0]         beat_cnt;

    logic                  pop;
    logic                  push;
    logic [2:0]            occ;

    assign pop  = m_valid && m_ready;
    // The word read last cycle lands this cycle.
    assign push = inflight;

    // Occupancy after this cycle's push/pop; a new read is only safe if it
    // will still find a free slot when its data arrives next cycle.
    assign occ       = {1'b0, count} + {2'b0, inflight} - {2'b0, pop};
    assign fifo_r_en = rst_n && !fifo_empty && (occ < 3'd2);

    assign m_valid = (count != 2'd0);
    assign m_data  = obuf[head];
    assign m_last  = (beat_cnt == LAST_BEAT) && m_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
            count    <= 2'd0;
            head     <= 1'b0;
            tail     <= 1'b0;
            obuf[0]  <= '0;
            obuf[1]  <= '0;
            beat_cnt <= '0;
        end else begin
            inflight <= fifo_r_en;
            if (push) begin
                obuf[tail] <= fifo_data;
                tail       <= ~tail;
            end
            if (pop) begin
                head     <= ~head;
                beat_cnt <= (beat_cnt == LAST_BEAT) ? '0 : beat_cnt + BW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

`ifdef FIFO_DRAIN_STAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beats_total <= 32'd0;
        end else if (pop) begin
            beats_total <= beats_total + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Purpose: randomized scoreboard bench for fifo_rd_stream_adapter with a behavioural FIFO upstream.
// Latency: checks read-to-valid spacing, sustained streaming and stall behaviour.
// Backpressure: m_ready driven constant, 1-0-0-1 pattern or random; monitor checks order and hold.
module tb_fifo_rd_stream_adapter;

    localparam int DW = 32;
    localparam int BL = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          fifo_empty;
    logic          fifo_r_en;
    logic [DW-1:0] fifo_data;
    logic          m_valid;
    logic          m_ready = 1'b0;
    logic [DW-1:0] m_data;
    logic          m_last;
`ifdef FIFO_DRAIN_STAT_EN
    logic [31:0]   beats_total;
`endif

    always #5 clk = ~clk;

    fifo_rd_stream_adapter #(.DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_r_en  (fifo_r_en),
        .fifo_data  (fifo_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last)
`ifdef FIFO_DRAIN_STAT_EN
        ,
        .beats_total(beats_total)
`endif
    );

    // Behavioural upstream FIFO: registered read data, shares rst_n.
    logic [DW-1:0] mem [256];
    logic [7:0]    wptr;
    logic [7:0]    rptr;
    logic          wr_req = 1'b0;
    logic [DW-1:0] wr_dat = '0;

    assign fifo_empty = (wptr == rptr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr      <= '0;
            rptr      <= '0;
            fifo_data <= '0;
        end else begin
            if (wr_req) begin
                mem[wptr] <= wr_dat;
                wptr      <= wptr + 8'd1;
            end
            if (fifo_r_en) begin
                fifo_data <= mem[rptr];
                rptr      <= rptr + 8'd1;
            end
        end
    end

    // Reference model and scoreboard state.
    logic [DW-1:0] wr_pending [$];
    logic [DW-1:0] exp_q [$];
    int            beat_model = 0;
    int            n_pops = 0;
    int            acc_since_rst = 0;
    int            total = 0;
    int            bad = 0;
    int            wr_gap_pct = 0;
    int            rdy_mode = 1;
    int            rdy_phase = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Writer: feeds pending words into the FIFO; each issued word becomes an expected output.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && wr_pending.size() > 0 && int'($urandom_range(99)) >= wr_gap_pct) begin
                wr_dat = wr_pending.pop_front();
                wr_req = 1'b1;
                exp_q.push_back(wr_dat);
            end else begin
                wr_req = 1'b0;
            end
        end
    end

    // Downstream ready driver.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: m_ready = 1'b0;
                1: m_ready = 1'b1;
                2: begin
                    m_ready = (rdy_phase % 4 == 0) || (rdy_phase % 4 == 3);
                    rdy_phase++;
                end
                default: m_ready = 1'($urandom_range(1));
            endcase
        end
    end

    // Monitor: samples on the falling edge, away from the DUT's active edge.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic          prev_last = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            chk("count_le_2", 64'(dut.count <= 2'd2), 64'd1);
            if (fifo_r_en) chk("read_while_empty", 64'(fifo_empty), 64'd0);
            if (!m_valid) chk("last_without_valid", 64'(m_last), 64'd0);
            if (prev_stall) begin
                chk("stall_valid", 64'(m_valid), 64'd1);
                chk("stall_data", 64'(m_data), 64'(prev_data));
                chk("stall_last", 64'(m_last), 64'(prev_last));
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_beat: got %0h expected none at %0t", m_data, $time);
                end else begin
                    logic [DW-1:0] e;
                    e = exp_q.pop_front();
                    chk("data", 64'(m_data), 64'(e));
                    chk("last", 64'(m_last), 64'(beat_model == BL - 1));
                    beat_model = (beat_model + 1) % BL;
                    n_pops++;
                    acc_since_rst++;
                end
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            prev_last  = m_last;
        end
    end

    task automatic check_reset_outputs();
        chk("rst_m_valid", 64'(m_valid), 64'd0);
        chk("rst_m_last", 64'(m_last), 64'd0);
        chk("rst_m_data", 64'(m_data), 64'd0);
        chk("rst_fifo_r_en", 64'(fifo_r_en), 64'd0);
`ifdef FIFO_DRAIN_STAT_EN
        chk("rst_beats_total", 64'(beats_total), 64'd0);
`endif
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        wr_req = 1'b0;
        wr_pending.delete();
        exp_q.delete();
        beat_model = 0;
        acc_since_rst = 0;
        #1;
        check_reset_outputs();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int maxc);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || wr_pending.size() != 0 || m_valid) && c < maxc) begin
            @(posedge clk);
            c++;
        end
        total++;
        if (c >= maxc) begin
            bad++;
            $display("FAIL drain_timeout: %0d words still expected after %0d cycles", exp_q.size(), maxc);
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int rdn, vcnt, rd_c, first_v, last_v, base, n;

        // Reset state.
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs();
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #2;

        // Single word: one read, valid two cycles later for one cycle.
        wr_pending.push_back(32'hA5A5_0001);
        rdn = 0; vcnt = 0; rd_c = -100; first_v = -1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (fifo_r_en) begin rdn++; rd_c = i; end
            if (m_valid) begin vcnt++; if (first_v < 0) first_v = i; end
        end
        chk("single_reads", 64'(rdn), 64'd1);
        chk("single_valid_cycles", 64'(vcnt), 64'd1);
        chk("single_latency", 64'(first_v - rd_c), 64'd2);
        wait_drain(50);

        // Streaming: 16 words back to back, bursts aligned from reset.
        do_reset();
        for (int i = 0; i < 16; i++) wr_pending.push_back(32'(i));
        vcnt = 0; first_v = -1; last_v = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (m_valid) begin
                vcnt++;
                if (first_v < 0) first_v = i;
                last_v = i;
            end
        end
        chk("stream_valid_cycles", 64'(vcnt), 64'd16);
        chk("stream_contiguous", 64'(last_v - first_v + 1), 64'd16);
        wait_drain(100);

        // Backpressure 1,0,0,1.
        rdy_phase = 0;
        rdy_mode = 2;
        for (int i = 0; i < 16; i++) wr_pending.push_back(32'(i));
        wait_drain(300);

        // Full stall: exactly two reads, first word held.
        rdy_mode = 0;
        repeat (2) @(posedge clk);
        #2;
        for (int i = 0; i < 16; i++) wr_pending.push_back(32'(i));
        rdn = 0;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            if (fifo_r_en) rdn++;
        end
        chk("stall_reads", 64'(rdn), 64'd2);
        chk("stall_m_valid", 64'(m_valid), 64'd1);
        chk("stall_m_data", 64'(m_data), 64'd0);
        rdy_mode = 1;
        wait_drain(200);

        // Reset after 3 of 8 accepted beats, then a clean burst of 8.
        do_reset();
        base = n_pops;
        for (int i = 0; i < 8; i++) wr_pending.push_back(32'h100 + 32'(i));
        for (int i = 0; i < 60 && (n_pops - base) < 3; i++) begin
            @(posedge clk);
            #2;
        end
        chk("midburst_pops", 64'(n_pops - base), 64'd3);
        do_reset();
        for (int i = 0; i < 8; i++) wr_pending.push_back(32'h200 + 32'(i));
        wait_drain(100);

        // 20 beats under random backpressure from a fresh reset.
        do_reset();
        rdy_mode = 3;
        for (int i = 0; i < 20; i++) wr_pending.push_back($urandom);
        wait_drain(1000);
        chk("accepted_20", 64'(acc_since_rst), 64'd20);
`ifdef FIFO_DRAIN_STAT_EN
        chk("beats_total_20", 64'(beats_total), 64'd20);
        do_reset();
`endif

        // Randomized rounds: random write gaps and random ready.
        for (int r = 0; r < 4; r++) begin
            wr_gap_pct = int'($urandom_range(60));
            rdy_mode = 3;
            n = int'($urandom_range(40, 10));
            for (int i = 0; i < n; i++) wr_pending.push_back($urandom);
            wait_drain(2000);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
